// File: rtl/spi_mem_ctrl_fsm_if.sv
// rtl/spi_mem_ctrl_fsm_if.sv - front-end inputs and memory enables of the SPI memory FSM
interface spi_mem_ctrl_fsm_if #(
    parameter int CNT_W = 4
);
    logic             cs_conditioned;
    logic             sclk_positiveedge;
    logic             shiftregp;
    logic             ADDR_we;
    logic             SR_we;
    logic             DM_we;
    logic             miso_buff;
    logic             addr_inc;
    logic             xfer_abort;
    logic             busy;
    logic [CNT_W-1:0] bit_count;

    modport slave (
        input  cs_conditioned, sclk_positiveedge, shiftregp,
        output ADDR_we, SR_we, DM_we, miso_buff, addr_inc, xfer_abort, busy, bit_count
    );

    modport master (
        output cs_conditioned, sclk_positiveedge, shiftregp,
        input  ADDR_we, SR_we, DM_we, miso_buff, addr_inc, xfer_abort, busy, bit_count
    );
endinterface

// File: rtl/spi_mem_ctrl_fsm.sv
// rtl/spi_mem_ctrl_fsm.sv - SPI memory transaction FSM (optional burst: SPI_MEM_BURST_EN)
module spi_mem_ctrl_fsm #(
    parameter int ADDR_BITS  = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_mem_ctrl_fsm_if.slave bus
);
    localparam int               HDR_BITS = ADDR_BITS + 1;
    localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [3:0] {
        S_GET, S_GOT, S_READ, S_READ2, S_READ3,
        S_WRITE, S_WRITE2, S_END_RD, S_END_WR, S_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_base;
    logic             clr_count;

    logic addr_we_d;
    logic sr_we_d;
    logic dm_we_d;
    logic miso_d;
    logic addr_inc_d;
    logic abort_d;
    logic busy_d;

    // State, edge counter and registered enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_GET;
            count          <= '0;
            bus.ADDR_we    <= 1'b0;
            bus.SR_we      <= 1'b0;
            bus.DM_we      <= 1'b0;
            bus.miso_buff  <= 1'b0;
            bus.addr_inc   <= 1'b0;
            bus.xfer_abort <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= next_state;
            count          <= count_next;
            bus.ADDR_we    <= addr_we_d;
            bus.SR_we      <= sr_we_d;
            bus.DM_we      <= dm_we_d;
            bus.miso_buff  <= miso_d;
            bus.addr_inc   <= addr_inc_d;
            bus.xfer_abort <= abort_d;
            bus.busy       <= busy_d;
        end
    end

    // Next state and next count; a deselect overrides everything
    always_comb begin
        next_state = state;
        clr_count  = 1'b0;
        case (state)
            S_GET:    if (count == HDR_CNT) next_state = S_GOT;
            S_GOT: begin
                clr_count  = 1'b1;
                next_state = bus.shiftregp ? S_READ : S_WRITE;
            end
            S_READ:   next_state = S_READ2;
            S_READ2:  next_state = S_READ3;
            S_READ3:  if (count == DATA_CNT) next_state = S_END_RD;
            S_WRITE: begin
                if (count == DATA_CNT) begin
                    clr_count  = 1'b1;
                    next_state = S_WRITE2;
                end
            end
            S_WRITE2: next_state = S_END_WR;
`ifdef SPI_MEM_BURST_EN
            S_END_RD: begin
                clr_count  = 1'b1;
                next_state = S_READ;
            end
            S_END_WR: begin
                clr_count  = 1'b1;
                next_state = S_WRITE;
            end
`else
            S_END_RD: next_state = S_DONE;
            S_END_WR: next_state = S_DONE;
`endif
            S_DONE:   next_state = S_DONE;
            default:  next_state = S_GET;
        endcase
        if (bus.cs_conditioned) next_state = S_GET;

        // An edge arriving on a clearing cycle still counts as the first one
        count_base = clr_count ? '0 : count;
        if (bus.cs_conditioned)
            count_next = '0;
        else if (count_base == CNT_MAX)
            count_next = count_base;
        else
            count_next = count_base + CNT_W'(bus.sclk_positiveedge);
    end

    // Enables decoded from the state being entered so they line up with it
    always_comb begin
        addr_we_d = (next_state == S_GOT);
        sr_we_d   = (next_state == S_READ2);
        dm_we_d   = (next_state == S_WRITE2);
        miso_d    = (next_state == S_READ3);
`ifdef SPI_MEM_BURST_EN
        addr_inc_d = (next_state == S_END_RD) || (next_state == S_END_WR);
`else
        addr_inc_d = 1'b0;
`endif
        abort_d = bus.cs_conditioned &&
                  (((state != S_GET) && (state != S_DONE)) ||
                   ((state == S_GET) && (count != '0)));
        busy_d  = !((next_state == S_GET) && (count_next == '0));
    end

    assign bus.bit_count = count;
endmodule

// File: doc/spi_mem_ctrl_fsm.md
Name: spi_mem_ctrl_fsm

Overview:
Parametrised successor to the SPI-memory transaction FSM. It counts conditioned SCLK rising-edge pulses while chip-select is active and decodes a header of ADDR_BITS address bits followed by one R/W bit. It then sequences address-latch, shift-register-load, MISO-buffer and data-memory write enables for DATA_WIDTH-bit words. It sits between the input conditioners/shift register and the address latch/data memory. It adds an active-low async reset, generic widths, CS-abort reporting and an optional burst mode.

Parameters:
ADDR_BITS, 7, address bits in header; header length HDR_BITS = ADDR_BITS+1 (R/W bit last)
DATA_WIDTH, 8, bits per data word
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > max(HDR_BITS, DATA_WIDTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs_conditioned  in  1  conditioned chip select; 1 = deselected
sclk_positiveedge  in  1  one-clk pulse per SCLK rising edge
shiftregp  in  1  shift-register parallel-out LSB (R/W bit); 1 = read, 0 = write
ADDR_we  out  1  address latch write enable
SR_we  out  1  shift-register parallel-load enable
DM_we  out  1  data memory write enable
miso_buff  out  1  MISO tri-state buffer enable
addr_inc  out  1  address-latch increment pulse (burst only)
xfer_abort  out  1  one-clk pulse when CS deasserts mid-transaction
busy  out  1  high in any state other than GET with count 0
bit_count  out  CNT_W  current SCLK edge count

Behaviour:
- Reset (rst_n = 0, async): state = GET, count = 0, all outputs 0.
- All outputs are registered and decoded from the next state. Each enable is high exactly during the clocks the FSM occupies the corresponding state.
- Counter: if cs_conditioned = 1, count <= 0. Otherwise count <= base + sclk_positiveedge, where base = 0 on a cycle the FSM clears the count, else count. An edge coinciding with a clear is counted, never lost.
- CS deassert overrides every state: next state = GET, count = 0, and no enable is asserted that cycle.
- xfer_abort pulses for one clk when CS rises while state is not GET and not DONE, or in GET with count != 0.
- GET: no enables. When count == HDR_BITS, go to GOT.
- GOT (1 clk): ADDR_we = 1, clear count. If shiftregp = 1, go to READ; otherwise go to WRITE.
- READ (1 clk): memory read latency, no enables. Go to READ2.
- READ2 (1 clk): SR_we = 1. Go to READ3.
- READ3: miso_buff = 1. When count == DATA_WIDTH, go to END_RD.
- WRITE: no enables. When count == DATA_WIDTH, clear count and go to WRITE2.
- WRITE2 (1 clk): DM_we = 1. Go to END_WR.
- END_RD / END_WR (1 clk each): burst decision, see Optional Feature. Without burst, go to DONE.
- DONE: all enables 0. Extra SCLK edges are counted but ignored. Stay until cs_conditioned = 1, then go to GET.
- Count saturates at 2^CNT_W-1 and never wraps.
- Latency: ADDR_we asserts 2 clk after the edge pulse that makes count == HDR_BITS (1 clk to register the count, 1 clk in GOT). DM_we asserts 2 clk after the DATA_WIDTH-th data edge.

Optional Feature:
Macro SPI_MEM_BURST_EN.
- Defined: in END_RD / END_WR with CS still low, addr_inc = 1 for 1 clk and count is cleared. END_RD goes to READ (next word reloaded); END_WR goes to WRITE. Continues until CS rises.
- Not defined: addr_inc is tied 0, and END_RD / END_WR always go to DONE. Single word per CS assertion.

Test Plan:
Write, defaults: CS low, 8 header edges with shiftregp = 0, then 8 data edges -> ADDR_we 1 clk; DM_we exactly 1 clk, 2 clk after the 16th edge; miso_buff and SR_we never high.
Read, defaults: 8 header edges with shiftregp = 1 -> ADDR_we 1 clk, SR_we 1 clk 2 clk later, miso_buff high until the 8th data edge; DM_we never high.
Abort: CS rises after 11 total edges during a write -> xfer_abort 1 clk; DM_we stays 0; state GET, count 0 on the next clk.
Async reset: assert rst_n low mid-READ3 between clk edges -> miso_buff drops immediately and all outputs are 0; after release, a clean 16-edge write completes normally.
Burst (SPI_MEM_BURST_EN): write header plus 24 data edges -> DM_we pulses 3 times and addr_inc pulses 3 times; with the macro undefined, only 1 DM_we and the remaining 16 edges are ignored in DONE.
Params: ADDR_BITS = 15, DATA_WIDTH = 16, CNT_W = 5 -> ADDR_we after 16 edges; DM_we after 16 further edges.
